// File: rtl/bc_ctrl_pkg.sv
// Shared types and constants for the basic-computer control sequencer:
// state encoding, control-array indices, bus codes and ALU op codes.
package bc_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_INIT,
    ST_T0,
    ST_T1,
    ST_T2,
    ST_T3,
    ST_T4,
    ST_T5,
    ST_T6,
    ST_HALT,
    ST_WAIT_STEP
  } state_t;

  // Control-array indices
  localparam int C_LD_AR  = 0;
  localparam int C_INR_AR = 1;
  localparam int C_CLR_AR = 2;
  localparam int C_LD_PC  = 3;
  localparam int C_INR_PC = 4;
  localparam int C_CLR_PC = 5;
  localparam int C_LD_DR  = 6;
  localparam int C_INR_DR = 7;
  localparam int C_CLR_DR = 8;
  localparam int C_LD_AC  = 9;
  localparam int C_INR_AC = 10;
  localparam int C_CLR_AC = 11;
  localparam int C_LD_IR  = 12;
  localparam int C_LD_TR  = 13;
  localparam int C_INR_TR = 14;
  localparam int C_CLR_TR = 15;
  localparam int C_MEM_WE = 16;
  localparam int C_LD_E   = 17;
  localparam int C_CMP_E  = 18;
  localparam int C_CLR_E  = 19;
  localparam int C_OPSEL  = 20;

  // Bus source codes
  localparam logic [2:0] BUS_AR   = 3'd0;
  localparam logic [2:0] BUS_PC   = 3'd1;
  localparam logic [2:0] BUS_DR   = 3'd2;
  localparam logic [2:0] BUS_AC   = 3'd3;
  localparam logic [2:0] BUS_IR   = 3'd4;
  localparam logic [2:0] BUS_TR   = 3'd5;
  localparam logic [2:0] BUS_MEM  = 3'd6;
  localparam logic [2:0] BUS_ZERO = 3'd7;

  // ALU operation codes
  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_XFR = 3'd2;
  localparam logic [2:0] OP_CMA = 3'd3;
  localparam logic [2:0] OP_SHR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;

  // Request produced by the register-reference decoder
  typedef struct packed {
    logic       clr_ac;
    logic       clr_e;
    logic       ld_ac;
    logic       ld_e;
    logic       cmp_e;
    logic       inr_ac;
    logic       skip;
    logic       halt;
    logic [2:0] opsel;
  } rr_req_t;

  // Timing-step number shown on SC_OUT; non-timing states read as 7
  function automatic logic [2:0] sc_of(state_t s);
    case (s)
      ST_T0:   return 3'd0;
      ST_T1:   return 3'd1;
      ST_T2:   return 3'd2;
      ST_T3:   return 3'd3;
      ST_T4:   return 3'd4;
      ST_T5:   return 3'd5;
      ST_T6:   return 3'd6;
      default: return 3'd7;
    endcase
  endfunction

endpackage

// File: rtl/bc_control_unit_if.sv
// Datapath-facing bundle of the control sequencer.
// Optional macro BC_SINGLE_STEP_EN adds the STEP input.
interface bc_control_unit_if #(
  parameter int WIDTH      = 16,
  parameter int CTRL_LNGTH = 21
);
  logic [WIDTH-1:0] IR_IN;
  logic [WIDTH-1:0] AC_IN;
  logic [WIDTH-1:0] DR_IN;
  logic             E_IN;
`ifdef BC_SINGLE_STEP_EN
  logic             STEP;
`endif
  logic [2:0]       BUS_SEL;
  logic [2:0]       CTRL_SGNLS [CTRL_LNGTH];
  logic [2:0]       SC_OUT;
  logic             HALTED;

  // Control unit side
  modport slave (
`ifdef BC_SINGLE_STEP_EN
    input  STEP,
`endif
    input  IR_IN, AC_IN, DR_IN, E_IN,
    output BUS_SEL, CTRL_SGNLS, SC_OUT, HALTED
  );

  // Datapath side
  modport master (
`ifdef BC_SINGLE_STEP_EN
    output STEP,
`endif
    output IR_IN, AC_IN, DR_IN, E_IN,
    input  BUS_SEL, CTRL_SGNLS, SC_OUT, HALTED
  );
endinterface

// File: rtl/bc_control_unit_reg_ref_decode.sv
// Priority decode of register-reference instructions: only the highest
// set bit of IR[11:0] takes effect; skips are resolved against AC/E here.
module bc_reg_ref_decode
  import bc_ctrl_pkg::*;
(
  input  logic [11:0] ir_bits,
  input  logic        ac_neg,
  input  logic        ac_zero,
  input  logic        e_flag,
  output rr_req_t     req
);

  // Highest set bit wins; all-zero operand field is a no-op
  always_comb begin
    req = '0;
    if (ir_bits[11])      req.clr_ac = 1'b1;
    else if (ir_bits[10]) req.clr_e  = 1'b1;
    else if (ir_bits[9]) begin
      req.ld_ac = 1'b1;
      req.opsel = OP_CMA;
    end
    else if (ir_bits[8])  req.cmp_e  = 1'b1;
    else if (ir_bits[7]) begin
      req.ld_ac = 1'b1;
      req.ld_e  = 1'b1;
      req.opsel = OP_SHR;
    end
    else if (ir_bits[6]) begin
      req.ld_ac = 1'b1;
      req.ld_e  = 1'b1;
      req.opsel = OP_SHL;
    end
    else if (ir_bits[5])  req.inr_ac = 1'b1;
    else if (ir_bits[4])  req.skip   = ~ac_neg;
    else if (ir_bits[3])  req.skip   = ac_neg;
    else if (ir_bits[2])  req.skip   = ac_zero;
    else if (ir_bits[1])  req.skip   = ~e_flag;
    else if (ir_bits[0])  req.halt   = 1'b1;
  end

endmodule

// File: rtl/bc_control_unit.sv
// Hardwired control sequencer for the basic computer: fetch/decode/execute
// timing T0..T6 with Moore-decoded bus select and control array.
// Optional macro BC_SINGLE_STEP_EN parks the FSM in WAIT_STEP before each
// instruction until STEP is seen high.
module bc_control_unit
  import bc_ctrl_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int CTRL_LNGTH = 21
) (
  input logic              clk,
  input logic              RST,
  bc_control_unit_if.slave bus
);

  localparam logic [2:0] ON = 3'd1;

`ifdef BC_SINGLE_STEP_EN
  localparam state_t ST_ENTRY = ST_WAIT_STEP;
`else
  localparam state_t ST_ENTRY = ST_T0;
`endif

  state_t     r_state;
  state_t     w_state_next;
  logic       r_i;
  logic [2:0] r_d;
  logic [2:0] w_bus;
  logic [2:0] w_ctrl [CTRL_LNGTH];
  logic [2:0] w_sc;
  logic       w_halted;
  rr_req_t    w_rr;

  bc_reg_ref_decode u_rr (
    .ir_bits (bus.IR_IN[11:0]),
    .ac_neg  (bus.AC_IN[WIDTH-1]),
    .ac_zero (bus.AC_IN == {WIDTH{1'b0}}),
    .e_flag  (bus.E_IN),
    .req     (w_rr)
  );

  // State register
  always_ff @(posedge clk) begin
    if (RST) r_state <= ST_INIT;
    else     r_state <= w_state_next;
  end

  // Latch indirect bit and opcode while IR is on the bus at T2
  always_ff @(posedge clk) begin
    if (RST) begin
      r_i <= 1'b0;
      r_d <= 3'd0;
    end else if (r_state == ST_T2) begin
      r_i <= bus.IR_IN[WIDTH-1];
      r_d <= bus.IR_IN[WIDTH-2 -: 3];
    end
  end

  // Next-state and Moore output decode; reset blanks outputs immediately
  always_comb begin
    w_state_next = r_state;
    w_bus        = BUS_ZERO;
    w_ctrl       = '{default: 3'd0};
    w_sc         = sc_of(r_state);
    w_halted     = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_ctrl[C_CLR_PC] = ON;
        w_ctrl[C_CLR_AC] = ON;
        w_ctrl[C_CLR_E]  = ON;
        w_ctrl[C_CLR_TR] = ON;
        w_state_next     = ST_ENTRY;
      end
      ST_T0: begin
        w_bus           = BUS_PC;
        w_ctrl[C_LD_AR] = ON;
        w_state_next    = ST_T1;
      end
      ST_T1: begin
        w_bus            = BUS_MEM;
        w_ctrl[C_LD_IR]  = ON;
        w_ctrl[C_INR_PC] = ON;
        w_state_next     = ST_T2;
      end
      ST_T2: begin
        w_bus           = BUS_IR;
        w_ctrl[C_LD_AR] = ON;
        w_state_next    = ST_T3;
      end
      ST_T3: begin
        if (r_d != 3'd7) begin
          if (r_i) begin
            w_bus           = BUS_MEM;
            w_ctrl[C_LD_AR] = ON;
          end
          w_state_next = ST_T4;
        end else if (!r_i) begin
          w_ctrl[C_CLR_AC] = {2'b00, w_rr.clr_ac};
          w_ctrl[C_CLR_E]  = {2'b00, w_rr.clr_e};
          w_ctrl[C_LD_AC]  = {2'b00, w_rr.ld_ac};
          w_ctrl[C_LD_E]   = {2'b00, w_rr.ld_e};
          w_ctrl[C_CMP_E]  = {2'b00, w_rr.cmp_e};
          w_ctrl[C_INR_AC] = {2'b00, w_rr.inr_ac};
          w_ctrl[C_INR_PC] = {2'b00, w_rr.skip};
          w_ctrl[C_OPSEL]  = w_rr.opsel;
          w_state_next     = w_rr.halt ? ST_HALT : ST_ENTRY;
        end else begin
          w_state_next = ST_ENTRY;
        end
      end
      ST_T4: begin
        w_state_next = ST_ENTRY;
        case (r_d)
          3'd0, 3'd1, 3'd2, 3'd6: begin
            w_bus           = BUS_MEM;
            w_ctrl[C_LD_DR] = ON;
            w_state_next    = ST_T5;
          end
          3'd3: begin
            w_bus            = BUS_AC;
            w_ctrl[C_MEM_WE] = ON;
          end
          3'd4: begin
            w_bus           = BUS_AR;
            w_ctrl[C_LD_PC] = ON;
          end
          3'd5: begin
            w_bus            = BUS_PC;
            w_ctrl[C_MEM_WE] = ON;
            w_ctrl[C_INR_AR] = ON;
            w_state_next     = ST_T5;
          end
          default: ;
        endcase
      end
      ST_T5: begin
        w_state_next = ST_ENTRY;
        case (r_d)
          3'd0: begin
            w_ctrl[C_OPSEL] = OP_AND;
            w_ctrl[C_LD_AC] = ON;
          end
          3'd1: begin
            w_ctrl[C_OPSEL] = OP_ADD;
            w_ctrl[C_LD_AC] = ON;
            w_ctrl[C_LD_E]  = ON;
          end
          3'd2: begin
            w_ctrl[C_OPSEL] = OP_XFR;
            w_ctrl[C_LD_AC] = ON;
          end
          3'd5: begin
            w_bus           = BUS_AR;
            w_ctrl[C_LD_PC] = ON;
          end
          3'd6: begin
            w_ctrl[C_INR_DR] = ON;
            w_state_next     = ST_T6;
          end
          default: ;
        endcase
      end
      ST_T6: begin
        // DR has already been incremented, so zero here means it wrapped
        w_bus            = BUS_DR;
        w_ctrl[C_MEM_WE] = ON;
        w_ctrl[C_INR_PC] = {2'b00, bus.DR_IN == {WIDTH{1'b0}}};
        w_state_next     = ST_ENTRY;
      end
      ST_HALT: begin
        w_halted = 1'b1;
      end
      ST_WAIT_STEP: begin
`ifdef BC_SINGLE_STEP_EN
        if (bus.STEP) w_state_next = ST_T0;
`else
        w_state_next = ST_T0;
`endif
      end
      default: w_state_next = ST_INIT;
    endcase
    if (RST) begin
      w_bus    = 3'd0;
      w_ctrl   = '{default: 3'd0};
      w_sc     = 3'd7;
      w_halted = 1'b0;
    end
  end

  assign bus.BUS_SEL = w_bus;
  assign bus.SC_OUT  = w_sc;
  assign bus.HALTED  = w_halted;

  // Drive the control array element by element
  for (genvar gi = 0; gi < CTRL_LNGTH; gi++) begin : g_ctrl
    assign bus.CTRL_SGNLS[gi] = w_ctrl[gi];
  end

endmodule

// File: tb/tb_bc_control_unit.sv
// Directed bench for bc_control_unit: walks reset, fetch, memory- and
// register-reference instructions, ISZ wrap skip, reset abort and HALT.
// Honours BC_SINGLE_STEP_EN by pulsing STEP at each WAIT_STEP visit.
module tb_bc_control_unit;
  import bc_ctrl_pkg::*;

  logic clk = 1'b0;
  logic RST = 1'b1;
  int   n_checks = 0;
  int   n_err    = 0;

  bc_control_unit_if #(.WIDTH(16), .CTRL_LNGTH(21)) bus_if ();

  bc_control_unit #(.WIDTH(16), .CTRL_LNGTH(21)) dut (
    .clk (clk),
    .RST (RST),
    .bus (bus_if.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] fl(input int idx);
    return 20'(1) << idx;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [2:0] e_sc, input logic [2:0] e_bus,
                     input logic [19:0] e_flags, input logic [2:0] e_op, input logic e_halt);
    logic [62:0] obs;
    logic [62:0] exp;
    for (int i = 0; i < 21; i++) obs[3*i +: 3] = bus_if.CTRL_SGNLS[i];
    exp = '0;
    for (int i = 0; i < 20; i++) exp[3*i] = e_flags[i];
    exp[60 +: 3] = e_op;
    n_checks++;
    assert (obs === exp)
      else begin n_err++; $error("FAIL %s ctrl observed=%h expected=%h", tag, obs, exp); end
    n_checks++;
    assert (bus_if.SC_OUT === e_sc)
      else begin n_err++; $error("FAIL %s sc observed=%0d expected=%0d", tag, bus_if.SC_OUT, e_sc); end
    n_checks++;
    assert (bus_if.BUS_SEL === e_bus)
      else begin n_err++; $error("FAIL %s bus observed=%0d expected=%0d", tag, bus_if.BUS_SEL, e_bus); end
    n_checks++;
    assert (bus_if.HALTED === e_halt)
      else begin n_err++; $error("FAIL %s halted observed=%0b expected=%0b", tag, bus_if.HALTED, e_halt); end
    $display("step %-12s sc=%0d bus=%0d halted=%0b", tag, bus_if.SC_OUT, bus_if.BUS_SEL, bus_if.HALTED);
  endtask

  // Arrive at T0 from a state whose successor is the instruction entry point
  task automatic enter_t0(input string tag);
`ifdef BC_SINGLE_STEP_EN
    chk({tag, "_w0"}, 3'd7, 3'd7, 20'd0, 3'd0, 1'b0);
    tick();
    chk({tag, "_w1"}, 3'd7, 3'd7, 20'd0, 3'd0, 1'b0);
    bus_if.STEP = 1'b1;
    tick();
    bus_if.STEP = 1'b0;
`else
    if (tag.len() == 0) $display("entry");
`endif
  endtask

  // From T0, run fetch and decode up to T3
  task automatic fetch(input string tag, input logic [15:0] ir);
    bus_if.IR_IN = ir;
    #1;
    chk({tag, "_t0"}, 3'd0, 3'd1, fl(C_LD_AR), 3'd0, 1'b0);
    tick();
    chk({tag, "_t1"}, 3'd1, 3'd6, fl(C_LD_IR) | fl(C_INR_PC), 3'd0, 1'b0);
    tick();
    chk({tag, "_t2"}, 3'd2, 3'd4, fl(C_LD_AR), 3'd0, 1'b0);
    tick();
  endtask

  // Single-cycle register-reference instruction, checked at T3
  task automatic rr_instr(input string tag, input logic [15:0] ir, input logic [15:0] ac,
                          input logic [19:0] e_flags, input logic [2:0] e_op);
    bus_if.AC_IN = ac;
    fetch(tag, ir);
    chk({tag, "_t3"}, 3'd3, 3'd7, e_flags, e_op, 1'b0);
    tick();
    enter_t0(tag);
  endtask

  initial begin
    bus_if.IR_IN = 16'h0000;
    bus_if.AC_IN = 16'h0000;
    bus_if.DR_IN = 16'h0000;
    bus_if.E_IN  = 1'b0;
`ifdef BC_SINGLE_STEP_EN
    bus_if.STEP  = 1'b0;
`endif

    // Reset held three cycles: everything zero, SC_OUT=7
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("reset", 3'd7, 3'd0, 20'd0, 3'd0, 1'b0);
    end
    RST = 1'b0;
    #1;
    chk("init", 3'd7, 3'd7, fl(C_CLR_PC) | fl(C_CLR_AC) | fl(C_CLR_E) | fl(C_CLR_TR), 3'd0, 1'b0);
    tick();
    enter_t0("init");

    // ADD direct
    fetch("add", 16'h1123);
    chk("add_t3", 3'd3, 3'd7, 20'd0, 3'd0, 1'b0);
    tick();
    chk("add_t4", 3'd4, 3'd6, fl(C_LD_DR), 3'd0, 1'b0);
    tick();
    chk("add_t5", 3'd5, 3'd7, fl(C_LD_AC) | fl(C_LD_E), 3'd1, 1'b0);
    tick();
    enter_t0("add");

    // ADD indirect
    fetch("addi", 16'h9123);
    chk("addi_t3", 3'd3, 3'd6, fl(C_LD_AR), 3'd0, 1'b0);
    tick();
    chk("addi_t4", 3'd4, 3'd6, fl(C_LD_DR), 3'd0, 1'b0);
    tick();
    chk("addi_t5", 3'd5, 3'd7, fl(C_LD_AC) | fl(C_LD_E), 3'd1, 1'b0);
    tick();
    enter_t0("addi");

    // ISZ with wrapped DR -> skip
    bus_if.DR_IN = 16'h0000;
    fetch("isz0", 16'h6050);
    chk("isz0_t3", 3'd3, 3'd7, 20'd0, 3'd0, 1'b0);
    tick();
    chk("isz0_t4", 3'd4, 3'd6, fl(C_LD_DR), 3'd0, 1'b0);
    tick();
    chk("isz0_t5", 3'd5, 3'd7, fl(C_INR_DR), 3'd0, 1'b0);
    tick();
    chk("isz0_t6", 3'd6, 3'd2, fl(C_MEM_WE) | fl(C_INR_PC), 3'd0, 1'b0);
    tick();
    enter_t0("isz0");

    // ISZ with nonzero DR -> no skip
    bus_if.DR_IN = 16'h0005;
    fetch("isz5", 16'h6050);
    tick();
    tick();
    tick();
    chk("isz5_t6", 3'd6, 3'd2, fl(C_MEM_WE), 3'd0, 1'b0);
    tick();
    enter_t0("isz5");

    // Register-reference cases
    rr_instr("sza0", 16'h7004, 16'h0000, fl(C_INR_PC), 3'd0);
    rr_instr("sza1", 16'h7004, 16'h0001, 20'd0, 3'd0);
    rr_instr("prio", 16'h7C00, 16'h0000, fl(C_CLR_AC), 3'd0);
    rr_instr("cil", 16'h7040, 16'h1234, fl(C_LD_AC) | fl(C_LD_E), 3'd5);
    rr_instr("spa", 16'h7010, 16'h8000, 20'd0, 3'd0);
    rr_instr("sna", 16'h7008, 16'h8000, fl(C_INR_PC), 3'd0);

    // STA aborted by reset at T4
    bus_if.AC_IN = 16'h0000;
    fetch("sta", 16'h3010);
    tick();
    chk("sta_t4", 3'd4, 3'd3, fl(C_MEM_WE), 3'd0, 1'b0);
    RST = 1'b1;
    #1;
    chk("sta_abort", 3'd7, 3'd0, 20'd0, 3'd0, 1'b0);
    tick();
    chk("sta_rst", 3'd7, 3'd0, 20'd0, 3'd0, 1'b0);
    RST = 1'b0;
    #1;
    chk("sta_init", 3'd7, 3'd7, fl(C_CLR_PC) | fl(C_CLR_AC) | fl(C_CLR_E) | fl(C_CLR_TR), 3'd0, 1'b0);
    tick();
    enter_t0("sta");

    // HLT, held until reset
    fetch("hlt", 16'h7001);
    chk("hlt_t3", 3'd3, 3'd7, 20'd0, 3'd0, 1'b0);
    tick();
    for (int k = 0; k < 10; k++) begin
      chk("halt", 3'd7, 3'd7, 20'd0, 3'd0, 1'b1);
      tick();
    end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    #1;
    chk("hlt_init", 3'd7, 3'd7, fl(C_CLR_PC) | fl(C_CLR_AC) | fl(C_CLR_E) | fl(C_CLR_TR), 3'd0, 1'b0);
    tick();
    enter_t0("post");
    chk("post_t0", 3'd0, 3'd1, fl(C_LD_AR), 3'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/bc_control_unit.md
Name: bc_control_unit

Overview:
- Hardwired control sequencer for the basic-computer datapath. Sits directly upstream of the datapath.
- Decodes the instruction register and steps a timing counter through T0..T6.
- Drives the bus select and the 21-entry control-signal array each cycle.
- Consumes AC, DR and E feedback for conditional skips and ISZ.

Parameters:
- WIDTH, 16, data word width
- CTRL_LNGTH, 21, number of control-signal entries

Ports:
- clk  in  1  clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- IR_IN  in  WIDTH  instruction register value
- AC_IN  in  WIDTH  accumulator value
- DR_IN  in  WIDTH  data register value
- E_IN  in  1  E flip-flop value
- BUS_SEL  out  3  bus source: 0 AR, 1 PC, 2 DR, 3 AC, 4 IR, 5 TR, 6 MEM, 7 zero
- CTRL_SGNLS  out  3 x CTRL_LNGTH  unpacked array; 1-bit signals occupy bit 0, upper bits 0
  - 0 LD_AR, 1 INR_AR, 2 CLR_AR
  - 3 LD_PC, 4 INR_PC, 5 CLR_PC
  - 6 LD_DR, 7 INR_DR, 8 CLR_DR
  - 9 LD_AC, 10 INR_AC, 11 CLR_AC
  - 12 LD_IR
  - 13 LD_TR, 14 INR_TR, 15 CLR_TR
  - 16 MEM_WE
  - 17 LD_E, 18 CMP_E, 19 CLR_E
  - 20 OPSEL_ALU[2:0]
- SC_OUT  out  3  current timing step (0..6); 7 in INIT/HALT
- HALTED  out  1  high while in HALT

Behaviour:
- General rules:
  - Memory read is asynchronous: MEM reflects M[AR] in the same cycle.
  - AC loads only from the ALU result.
  - All outputs are Moore decodes of the state, plus registered I and D latched at T2.
  - Any signal not listed for a step is 0. BUS_SEL defaults to 7.
- Reset: while RST=1, all outputs are 0, SC_OUT=7, HALTED=0. The next state is INIT. Reset asserted mid-instruction aborts it with no further side effects.
- INIT (1 cycle): CLR_PC, CLR_AC, CLR_E, CLR_TR -> T0.
- T0: BUS_SEL=1, LD_AR -> T1.
- T1: BUS_SEL=6, LD_IR, INR_PC -> T2.
- T2:
  - BUS_SEL=4, LD_AR (loads IR[11:0]).
  - Latch I=IR_IN[15] and D=IR_IN[14:12] into decode registers -> T3.
- T3:
  - D!=7 and I=1: BUS_SEL=6, LD_AR (indirect) -> T4.
  - D!=7 and I=0: no-op -> T4.
  - D=7 and I=0: register-reference (see below) -> T0, or HALT on HLT.
  - D=7 and I=1: I/O, executed as a no-op -> T0.
- Memory-reference instructions:
  - AND (D=0): T4 BUS_SEL=6, LD_DR; T5 OPSEL=AND, LD_AC -> T0.
  - ADD (D=1): T4 BUS_SEL=6, LD_DR; T5 OPSEL=ADD, LD_AC, LD_E -> T0.
  - LDA (D=2): T4 BUS_SEL=6, LD_DR; T5 OPSEL=XFR, LD_AC -> T0.
  - STA (D=3): T4 BUS_SEL=3, MEM_WE -> T0.
  - BUN (D=4): T4 BUS_SEL=0, LD_PC -> T0.
  - BSA (D=5): T4 BUS_SEL=1, MEM_WE, INR_AR; T5 BUS_SEL=0, LD_PC -> T0.
  - ISZ (D=6):
    - T4 BUS_SEL=6, LD_DR.
    - T5 INR_DR.
    - T6 BUS_SEL=2, MEM_WE; INR_PC if DR_IN==0 -> T0.
    - DR wraps 0xFFFF -> 0x0000, which causes the skip.
- Register-reference: only the highest set bit of IR[11:0] is executed; IR[11:0]=0 is a no-op.
  - b11 CLA: CLR_AC
  - b10 CLE: CLR_E
  - b9 CMA: OPSEL=CMA, LD_AC
  - b8 CME: CMP_E
  - b7 CIR: OPSEL=SHR, LD_AC, LD_E
  - b6 CIL: OPSEL=SHL, LD_AC, LD_E
  - b5 INC: INR_AC
  - b4 SPA: INR_PC if AC_IN[15]=0
  - b3 SNA: INR_PC if AC_IN[15]=1
  - b2 SZA: INR_PC if AC_IN==0
  - b1 SZE: INR_PC if E_IN=0
  - b0 HLT: -> HALT
- HALT: all controls 0, HALTED=1. Left only by RST.

Optional Feature:
- Macro: BC_SINGLE_STEP_EN.
- When defined:
  - Adds input STEP (1 bit) and state WAIT_STEP.
  - Every transition into T0 goes to WAIT_STEP instead; all controls are 0 there and SC_OUT=7.
  - WAIT_STEP -> T0 on a cycle with STEP=1; STEP held high releases one instruction per visit.
  - INIT also goes to WAIT_STEP.
- When undefined: no STEP port; behaviour exactly as above.

Decomposition:
- Package bc_ctrl_pkg holds:
  - state enum (INIT, T0..T6, HALT, WAIT_STEP)
  - control-index localparams 0..20
  - bus-select codes 0..7
  - OPSEL codes: AND=0, ADD=1, XFR=2, CMA=3, SHR=4, SHL=5, others reserved
- One sub-module, bc_reg_ref_decode: combinational priority decode of IR[11:0] plus AC/E flags into a skip/clear/op request.
- The sequencer FSM stays in the top.

Test Plan:
- RST high 3 cycles, then low -> outputs 0 during reset; INIT asserts CLR_PC/CLR_AC/CLR_E; next cycle T0 with BUS_SEL=1, LD_AR.
- IR_IN=0x1123 (ADD direct) -> T0..T5 sequence; T5 has OPSEL=1, LD_AC=1, LD_E=1; returns to T0; SC_OUT 0,1,2,3,4,5.
- IR_IN=0x9123 (ADD indirect) -> T3 BUS_SEL=6, LD_AR=1; T5 ADD as above.
- IR_IN=0x6050 (ISZ), DR_IN=0x0000 at T6 -> T6 MEM_WE=1, BUS_SEL=2, INR_PC=1; repeat with DR_IN=0x0005 -> INR_PC=0.
- IR_IN=0x7004 (SZA) with AC_IN=0 -> INR_PC at T3; IR_IN=0x7C00 -> only CLR_AC (priority); IR_IN=0x7001 -> HALTED=1 held 10 cycles until RST.
- RST asserted during T4 of STA -> MEM_WE=0 on that cycle, then INIT; with BC_SINGLE_STEP_EN, FSM waits in WAIT_STEP until STEP=1.
